dht22_sensor_emu: RTL and testbench

Single-wire DHT22 responder: models the sensor end of the DHT22 protocol so the host-side reader and its AXI-lite wrapper can be exercised in simulation and in hardware-in-the-loop rigs without a physical sensor. It detects the host start pulse on the shared open-drain line and answers with the standard 80 µs / 80 µs preamble, then 40 data bits. The bits are 16-bit humidity, 16-bit temperature and an 8-bit checksum, sent MSB first. The block sits on the same `dht22_in_out` net as the reader, with an external or modelled pull-up.

---
 rtl/dht22_sensor_emu.sv | 148 ++++++++++++++
 tb/tb_dht22_sensor_emu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dht22_sensor_emu.sv
// DHT22 sensor-side responder: waits for a long host low pulse, then drives the
// preamble and 40 data bits {humidity, temperature, checksum} MSB first on the open-drain line.
// state     | meaning
// IDLE      | measure host low pulse, latch frame on release
// WAIT      | line released before responding
// RESP_LOW  | preamble low phase
// RESP_HIGH | preamble high phase
// BIT_LOW   | low phase ahead of each bit
// BIT_HIGH  | released, length encodes the bit value
// END_LOW   | trailing low after the last bit
`timescale 1ns/1ps
module dht22_sensor_emu #(
   parameter int unsigned CLK_FREQ       = 100_000_000,
   parameter int unsigned T_START_MIN_US = 500,
   parameter int unsigned T_WAIT_US      = 30,
   parameter int unsigned T_RESP_LOW_US  = 80,
   parameter int unsigned T_RESP_HIGH_US = 80,
   parameter int unsigned T_BIT_LOW_US   = 50,
   parameter int unsigned T_BIT0_HIGH_US = 26,
   parameter int unsigned T_BIT1_HIGH_US = 70,
   parameter int unsigned T_END_LOW_US   = 50
) (
   input  logic        clk,
   input  logic        arst,
   inout  wire         dht22_in_out,
   input  logic [15:0] humidity,
   input  logic [15:0] temperature,
   input  logic        corrupt_crc,
   output logic        busy,
   output logic        frame_done
);

   localparam int unsigned US      = CLK_FREQ / 1_000_000;
   localparam int unsigned C_START = T_START_MIN_US * US;
   localparam int unsigned C_MAX   = (C_START > T_RESP_LOW_US * US) ? C_START : T_RESP_LOW_US * US;
   localparam int unsigned C_ALL   = (C_MAX > T_RESP_HIGH_US * US) ? C_MAX : T_RESP_HIGH_US * US;
   localparam int unsigned C_TOP   = (C_ALL > T_BIT1_HIGH_US * US) ? C_ALL : T_BIT1_HIGH_US * US;
   localparam int          CW      = $clog2(C_TOP + 1);

   localparam logic [CW-1:0] SAT        = CW'(C_START);
   localparam logic [CW-1:0] L_WAIT     = CW'(T_WAIT_US * US - 1);
   localparam logic [CW-1:0] L_RESP_LOW = CW'(T_RESP_LOW_US * US - 1);
   localparam logic [CW-1:0] L_RESP_HI  = CW'(T_RESP_HIGH_US * US - 1);
   localparam logic [CW-1:0] L_BIT_LOW  = CW'(T_BIT_LOW_US * US - 1);
   localparam logic [CW-1:0] L_BIT0     = CW'(T_BIT0_HIGH_US * US - 1);
   localparam logic [CW-1:0] L_BIT1     = CW'(T_BIT1_HIGH_US * US - 1);
   localparam logic [CW-1:0] L_END      = CW'(T_END_LOW_US * US - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q;
   logic          line_s;
   logic [CW-1:0] phase_q, phase_d;
   logic [CW-1:0] low_q, low_d;
   logic [5:0]    bit_q, bit_d;
   logic [39:0]   frame_q, frame_d;
   logic          done_d;
   logic          drive_low;
   logic          phase_end;
   logic [9:0]    sum;
   logic [7:0]    chk;

   assign line_s       = sync_q[1];
   assign busy         = (state_q != IDLE);
   assign phase_end    = (phase_q == '0);
   assign dht22_in_out = drive_low ? 1'b0 : 1'bz;

   assign sum = 10'(humidity[15:8]) + 10'(humidity[7:0])
              + 10'(temperature[15:8]) + 10'(temperature[7:0]);
   assign chk = 8'(sum) ^ {8{corrupt_crc}};

   always_comb begin
      state_d = state_q;
      phase_d = phase_end ? phase_q : phase_q - 1'b1;
      low_d   = low_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!line_s) begin
               if (low_q != SAT) low_d = low_q + 1'b1;
            end else begin
               low_d = '0;
               if (low_q == SAT) begin
                  state_d = WAIT;
                  phase_d = L_WAIT;
                  frame_d = {humidity, temperature, chk};
               end
            end
         end
         WAIT:      if (phase_end) begin state_d = RESP_LOW;  phase_d = L_RESP_LOW; end
         RESP_LOW:  if (phase_end) begin state_d = RESP_HIGH; phase_d = L_RESP_HI;  end
         RESP_HIGH: if (phase_end) begin
            state_d = BIT_LOW;
            phase_d = L_BIT_LOW;
            bit_d   = 6'd39;
         end
         BIT_LOW: if (phase_end) begin
            state_d = BIT_HIGH;
            phase_d = frame_q[bit_q] ? L_BIT1 : L_BIT0;
         end
         BIT_HIGH: if (phase_end) begin
            if (bit_q == 6'd0) begin
               state_d = END_LOW;
               phase_d = L_END;
            end else begin
               state_d = BIT_LOW;
               phase_d = L_BIT_LOW;
               bit_d   = bit_q - 1'b1;
            end
         end
         END_LOW: if (phase_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
            low_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // drive_low is computed from the next state so it lines up with state_q
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         phase_q    <= '0;
         low_q      <= '0;
         bit_q      <= '0;
         frame_q    <= '0;
         drive_low  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[0], dht22_in_out};
         phase_q    <= phase_d;
         low_q      <= low_d;
         bit_q      <= bit_d;
         frame_q    <= frame_d;
         drive_low  <= (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
         frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_dht22_sensor_emu.sv
// Bench for dht22_sensor_emu at 1 cycle per us: host start pulses, phase-length
// measurement of the response and bit decoding against hand-computed frames.
`timescale 1ns/1ps
module tb_dht22_sensor_emu;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        host_low = 1'b0;
   logic [15:0] humidity = '0;
   logic [15:0] temperature = '0;
   logic        corrupt_crc = 1'b0;
   logic        busy;
   logic        frame_done;
   wire         line;

   assign line = host_low ? 1'b0 : 1'bz;
   pullup (line);

   always #5 clk = ~clk;

   dht22_sensor_emu #(.CLK_FREQ(1_000_000)) dut (
      .clk          (clk),
      .arst         (arst),
      .dht22_in_out (line),
      .humidity     (humidity),
      .temperature  (temperature),
      .corrupt_crc  (corrupt_crc),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   typedef struct {
      logic [15:0] hum;
      logic [15:0] temp;
      logic        crc;
      logic [7:0]  chk;
   } vec_t;

   vec_t vecs[5];
   int   total = 0;
   int   bad = 0;
   localparam logic [39:0] NOM = 40'h028C_015F_EE;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic host_start(input int n);
      @(negedge clk);
      host_low = 1'b1;
      repeat (n) @(negedge clk);
      host_low = 1'b0;
   endtask

   task automatic run_len(input logic v, output int n);
      n = 0;
      while (line === v && n < 3000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_busy(output int lat);
      lat = 0;
      while (busy !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic rx_frame(input logic [39:0] exp, input logic flip, output logic [39:0] got);
      int lat, n, len, n1;
      got = '0;
      wait_busy(lat);
      check("start_latency", lat, 3);
      if (lat >= 20) return;
      if (flip) begin
         humidity    = ~humidity;
         temperature = ~temperature;
         corrupt_crc = ~corrupt_crc;
      end
      run_len(1'b1, n); check("wait_len", n, 30);      len = n;
      run_len(1'b0, n); check("resp_low_len", n, 80);  len += n;
      run_len(1'b1, n); check("resp_high_len", n, 80); len += n;
      for (int i = 39; i >= 0; i--) begin
         run_len(1'b0, n); check("bit_low_len", n, 50); len += n;
         run_len(1'b1, n); check("bit_high_len", n, exp[i] ? 70 : 26); len += n;
         got[i] = (n > 48);
      end
      run_len(1'b0, n); check("end_low_len", n, 50); len += n;
      n1 = $countones(exp);
      check("frame_len", len, 30 + 160 + 2000 + n1 * 70 + (40 - n1) * 26 + 50);
      check("frame_done_pulse", frame_done, 1);
      check("busy_fall", busy, 0);
      check("frame_data", got, exp);
      @(negedge clk);
      check("frame_done_clear", frame_done, 0);
   endtask

   initial begin
      logic [39:0] got;
      int lat, n, busy_seen, low_seen;

      vecs[0] = '{16'h028C, 16'h015F, 1'b0, 8'hEE};
      vecs[1] = '{16'h0190, 16'h8065, 1'b0, 8'h76};
      vecs[2] = '{16'h028C, 16'h015F, 1'b1, 8'h11};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 8'hFC};
      vecs[4] = '{16'h0000, 16'h0000, 1'b1, 8'hFF};

      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", frame_done, 0);
      check("reset_line", line, 1);
      arst = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         humidity    = vecs[i].hum;
         temperature = vecs[i].temp;
         corrupt_crc = vecs[i].crc;
         repeat (20) @(negedge clk);
         host_start(1000);
         rx_frame({vecs[i].hum, vecs[i].temp, vecs[i].chk}, 1'b1, got);
      end

      // short start pulse must be ignored, the minimum one accepted
      humidity = 16'h028C; temperature = 16'h015F; corrupt_crc = 1'b0;
      repeat (20) @(negedge clk);
      host_start(499);
      busy_seen = 0;
      low_seen = 0;
      repeat (600) begin
         @(negedge clk);
         if (busy === 1'b1) busy_seen++;
         if (line === 1'b0) low_seen++;
      end
      check("short_busy", busy_seen, 0);
      check("short_drive", low_seen, 0);
      host_start(500);
      rx_frame(NOM, 1'b0, got);

      // reset during bit 12 releases the line without a clock edge
      repeat (20) @(negedge clk);
      host_start(1000);
      wait_busy(lat);
      check("rst_start_latency", lat, 3);
      run_len(1'b1, n);
      run_len(1'b0, n);
      run_len(1'b1, n);
      for (int b = 0; b < 12; b++) begin
         run_len(1'b0, n);
         run_len(1'b1, n);
      end
      repeat (20) @(negedge clk);
      check("drive_before_reset", line, 0);
      check("busy_before_reset", busy, 1);
      #2 arst = 1'b1;
      #1;
      check("reset_release", line, 1);
      check("reset_busy_mid", busy, 0);
      repeat (5) @(negedge clk);
      arst = 1'b0;
      repeat (10) @(negedge clk);
      host_start(1000);
      rx_frame(NOM, 1'b0, got);

      // back-to-back: new request 100 us after frame_done
      repeat (20) @(negedge clk);
      host_start(1000);
      rx_frame(NOM, 1'b0, got);
      repeat (98) @(negedge clk);
      host_start(1000);
      rx_frame(NOM, 1'b0, got);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
